vga_timing_ctrl: RTL and testbench

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

---
 rtl/vga_timing_ctrl_pkg.sv | 41 ++++
 rtl/vga_timing_ctrl_sync_delay.sv | 37 +++
 rtl/vga_timing_ctrl.sv | 137 +++++++++++++
 tb/tb_vga_timing_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_ctrl_pkg
// Description : Shared 640x480@60 VGA timing constants and types. The video
//               timing block and the page renderers both take their
//               geometry from here.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_ctrl_pkg;

    // Horizontal timing, in pixel clocks (25 MHz)
    localparam int VGA_H_SYNC     = 96;
    localparam int VGA_H_BACK     = 48;
    localparam int VGA_H_ACTIVE   = 640;
    localparam int VGA_H_FRONT    = 16;

    // Vertical timing, in lines
    localparam int VGA_V_SYNC     = 2;
    localparam int VGA_V_BACK     = 33;
    localparam int VGA_V_ACTIVE   = 480;
    localparam int VGA_V_FRONT    = 10;

    // Visible raster, shared with the page renderers
    localparam int VGA_WIDTH      = VGA_H_ACTIVE;
    localparam int VGA_HEIGHT     = VGA_V_ACTIVE;

    // Default blink half-period exponent (frames)
    localparam int VGA_BLINK_LOG2 = 5;

    // Datapath widths
    localparam int CNT_W          = 10;
    localparam int RGB_W          = 16;

    // Raw sync pair travelling down the delay pipeline
    typedef struct packed {
        logic hs;
        logic vs;
    } sync_pair_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_ctrl_sync_delay.sv
`default_nettype none
// ============================================================================
// Module      : sync_delay
// Description : Parameterised STAGES-deep, WIDTH-wide shift register used to
//               align raw sync/enable decodes with the pixel data path.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_delay #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the input through the stages; all stages clear on reset
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout_o = stage_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_ctrl
// Description : VGA raster timing generator. Issues pixel requests to the
//               page renderer, receives the pixel one cycle later and drives
//               hsync/vsync/rgb aligned two cycles after the request.
//               Also produces a frame-origin pulse and a slow blink bit.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl
    import vga_timing_ctrl_pkg::*;
#(
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BACK     = VGA_H_BACK,
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FRONT    = VGA_H_FRONT,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BACK     = VGA_V_BACK,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FRONT    = VGA_V_FRONT,
    parameter int BLINK_LOG2 = VGA_BLINK_LOG2
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    input  logic [15:0]      pix_data,
    output logic [9:0]       pix_x,
    output logic [9:0]       pix_y,
    output logic             pix_valid,
    output logic             hsync,
    output logic             vsync,
    output logic [15:0]      rgb,
    output logic             frame_start,
    output logic             blink
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    // Counter limits and active window bounds, all unsigned
    localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_LO = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] H_ACT_HI = CNT_W'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_LO = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] V_ACT_HI = CNT_W'(V_SYNC + V_BACK + V_ACTIVE - 1);

    logic [CNT_W-1:0]    cnt_h_q, cnt_h_d;
    logic [CNT_W-1:0]    cnt_v_q, cnt_v_d;
    logic [BLINK_LOG2:0] blink_cnt_q, blink_cnt_d;
    logic                frame_start_q, frame_start_d;
    logic [RGB_W-1:0]    rgb_q, rgb_d;

    logic                h_wrap;
    logic                h_act, v_act;
    sync_pair_t          sync_raw, sync_dly;
    logic                de_dly1;

    // Next-state for the raster counters; cnt_v only moves on a line wrap
    always_comb begin
        h_wrap  = (cnt_h_q == H_MAX);
        cnt_h_d = h_wrap ? '0 : cnt_h_q + CNT_W'(1);
        cnt_v_d = cnt_v_q;
        if (h_wrap) begin
            cnt_v_d = (cnt_v_q == V_MAX) ? '0 : cnt_v_q + CNT_W'(1);
        end
    end

    // Active-area decode and pixel request address straight off the counters
    always_comb begin
        h_act     = (cnt_h_q >= H_ACT_LO) && (cnt_h_q <= H_ACT_HI);
        v_act     = (cnt_v_q >= V_ACT_LO) && (cnt_v_q <= V_ACT_HI);
        pix_valid = h_act && v_act;
        pix_x     = pix_valid ? (cnt_h_q - H_ACT_LO) : '0;
        pix_y     = pix_valid ? (cnt_v_q - V_ACT_LO) : '0;
        sync_raw.hs = (cnt_h_q < H_SYNC_C);
        sync_raw.vs = (cnt_v_q < V_SYNC_C);
    end

    // Frame pulse follows the origin by one cycle; blink counter steps with it
    // so blink changes on the same cycle the frame_start pulse is seen
    always_comb begin
        frame_start_d = (cnt_h_q == '0) && (cnt_v_q == '0);
        blink_cnt_d   = frame_start_d ? blink_cnt_q + (BLINK_LOG2 + 1)'(1)
                                      : blink_cnt_q;
        // pix_data returns one cycle after its request, matching de_dly1
        rgb_d         = de_dly1 ? pix_data : '0;
    end

    // State registers; everything clears asynchronously on reset
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h_q       <= '0;
            cnt_v_q       <= '0;
            blink_cnt_q   <= '0;
            frame_start_q <= 1'b0;
            rgb_q         <= '0;
        end else begin
            cnt_h_q       <= cnt_h_d;
            cnt_v_q       <= cnt_v_d;
            blink_cnt_q   <= blink_cnt_d;
            frame_start_q <= frame_start_d;
            rgb_q         <= rgb_d;
        end
    end

    // hs/vs travel two stages to line up with the registered rgb
    sync_delay #(
        .STAGES (2),
        .WIDTH  ($bits(sync_pair_t))
    ) u_sync_dly (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .din_i     (sync_raw),
        .dout_o    (sync_dly)
    );

    // Data enable takes one stage here; the rgb register is its second stage
    sync_delay #(
        .STAGES (1),
        .WIDTH  (1)
    ) u_de_dly (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .din_i     (pix_valid),
        .dout_o    (de_dly1)
    );

    assign hsync       = ~sync_dly.hs;
    assign vsync       = ~sync_dly.vs;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;
    assign blink       = blink_cnt_q[BLINK_LOG2];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_ctrl
// Description : Scoreboard bench for vga_timing_ctrl on a shrunken raster
//               (17 x 10 = 170 cycles per frame, blink every 4 frames).
//               A request-side process checks the combinational outputs and
//               queues the expected hsync/vsync/rgb; a monitor pops and
//               compares them two cycles later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

    // Shrunken raster: H 4+3+8+2 = 17, V 2+2+5+1 = 10
    localparam int FRAME = 170;
    localparam int H_LO  = 7;
    localparam int H_HI  = 14;
    localparam int V_LO  = 4;
    localparam int V_HI  = 8;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic [15:0] pix_data = '0;
    logic [9:0]  pix_x, pix_y;
    logic        pix_valid, hsync, vsync, frame_start, blink;
    logic [15:0] rgb;

    vga_timing_ctrl #(
        .H_SYNC (4), .H_BACK (3), .H_ACTIVE (8), .H_FRONT (2),
        .V_SYNC (2), .V_BACK (2), .V_ACTIVE (5), .V_FRONT (1),
        .BLINK_LOG2 (2)
    ) dut (
        .vga_clk     (vga_clk),
        .sys_rst_n   (sys_rst_n),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_valid   (pix_valid),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .frame_start (frame_start),
        .blink       (blink)
    );

    always #5 vga_clk = ~vga_clk;

    // Renderer stand-in: registered pixel built from the request address
    always @(posedge vga_clk) pix_data <= {pix_y[5:0], pix_x};

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [15:0] rgb;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Bench raster model and recorded observations
    int   m_h, m_v, cyc;
    bit   prev_org;
    int   fs_cyc[$];
    bit   fs_blink[$];
    int   first_v_cyc, last_v_cyc, last_x, last_y, valid_cnt;
    logic       e_valid;
    logic [9:0] e_x, e_y;

    // Request side: check decode outputs, queue expected delayed outputs
    always @(negedge vga_clk) begin
        if (!sys_rst_n) begin
            m_h = 0; m_v = 0; cyc = 0; prev_org = 1'b0;
            sb.delete(); fs_cyc.delete(); fs_blink.delete();
            first_v_cyc = -1; last_v_cyc = -1; last_x = -1; last_y = -1; valid_cnt = 0;
        end else begin
            e_valid = (m_h >= H_LO) && (m_h <= H_HI) && (m_v >= V_LO) && (m_v <= V_HI);
            e_x     = e_valid ? 10'(m_h - H_LO) : 10'd0;
            e_y     = e_valid ? 10'(m_v - V_LO) : 10'd0;
            chk("pix_valid", 32'(pix_valid), 32'(e_valid));
            chk("pix_x", 32'(pix_x), 32'(e_x));
            chk("pix_y", 32'(pix_y), 32'(e_y));
            chk("frame_start", 32'(frame_start), 32'(prev_org));
            if (frame_start) begin
                fs_cyc.push_back(cyc);
                fs_blink.push_back(blink);
            end
            if (e_valid && cyc < FRAME) begin
                if (first_v_cyc < 0) first_v_cyc = cyc;
                last_v_cyc = cyc;
                last_x = int'(e_x);
                last_y = int'(e_y);
                valid_cnt++;
            end
            sb.push_back({~(m_h < 4), ~(m_v < 2), e_valid ? {e_y[5:0], e_x} : 16'h0000});
            prev_org = (m_h == 0) && (m_v == 0);
            if (m_h == 16) begin
                m_h = 0;
                m_v = (m_v == 9) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
            cyc++;
        end
    end

    // Monitor: compare the delayed outputs against the queued expectation
    always @(negedge vga_clk) begin
        #1;
        if (sys_rst_n && sb.size() > 2) begin
            mon_e = sb.pop_front();
            chk("hsync", 32'(hsync), 32'(mon_e.hs));
            chk("vsync", 32'(vsync), 32'(mon_e.vs));
            chk("rgb", 32'(rgb), 32'(mon_e.rgb));
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hsync"}, 32'(hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vsync), 32'd1);
        chk({tag, "_rgb"}, 32'(rgb), 32'd0);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, "_blink"}, 32'(blink), 32'd0);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_pix_x"}, 32'(pix_x), 32'd0);
        chk({tag, "_pix_y"}, 32'(pix_y), 32'd0);
    endtask

    initial begin
        bit found;
        sys_rst_n = 1'b0;
        repeat (3) @(posedge vga_clk);
        #3;
        chk_reset_outputs("por");
        @(posedge vga_clk);
        #2 sys_rst_n = 1'b1;

        // Run until five frames have started so blink is high
        for (int i = 0; i < 2000 && fs_cyc.size() < 5; i++) @(posedge vga_clk);
        chk("five_frames_seen", 32'(fs_cyc.size() >= 5), 32'd1);

        // Find the mid-frame point h=10, v=5
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge vga_clk);
            #2;
            if (m_h == 10 && m_v == 5) begin
                found = 1'b1;
                break;
            end
        end
        chk("midframe_found", 32'(found), 32'd1);
        chk("blink_before_rst", 32'(blink), 32'd1);

        // Asynchronous assertion, checked before any clock edge
        sys_rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        repeat (3) @(posedge vga_clk);
        #2 sys_rst_n = 1'b1;

        repeat (9 * FRAME + 10) @(posedge vga_clk);
        #3;
        chk("fs_count", 32'(fs_cyc.size() >= 9), 32'd1);
        if (fs_cyc.size() >= 9) begin
            chk("fs_first_after_rel", 32'(fs_cyc[0]), 32'd1);
            chk("fs_period_1", 32'(fs_cyc[1] - fs_cyc[0]), 32'(FRAME));
            chk("fs_period_8", 32'(fs_cyc[8] - fs_cyc[7]), 32'(FRAME));
            chk("fs_ninth", 32'(fs_cyc[8]), 32'(1 + 8 * FRAME));
            chk("blink_fs1", 32'(fs_blink[0]), 32'd0);
            chk("blink_fs3", 32'(fs_blink[2]), 32'd0);
            chk("blink_fs4", 32'(fs_blink[3]), 32'd1);
            chk("blink_fs7", 32'(fs_blink[6]), 32'd1);
            chk("blink_fs8", 32'(fs_blink[7]), 32'd0);
            chk("blink_fs9", 32'(fs_blink[8]), 32'd0);
        end
        chk("first_valid_cyc", 32'(first_v_cyc), 32'd75);
        chk("last_valid_cyc", 32'(last_v_cyc), 32'd150);
        chk("last_valid_x", 32'(last_x), 32'd7);
        chk("last_valid_y", 32'(last_y), 32'd4);
        chk("valid_per_frame", 32'(valid_cnt), 32'd40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case the sequence above stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors %0d", n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
